a0_uart_monitor: RTL and testbench
==================================

A0_UART_MONITOR -- requirements
Module: a0_uart_monitor

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (min 2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of 32-bit words buffered (power of 2, min 2).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port a0  input  32  register x10 value from the CPU core, sampled every cycle.
REQ-006 SHALL have port en  input  1  capture enable; when low, a0 changes are not captured.
REQ-007 SHALL have port clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-008 SHALL have port tx  output  1  UART serial line, 8N1, idle high.
REQ-009 SHALL have port busy  output  1  high when a frame is in progress or the FIFO is non-empty.
REQ-010 SHALL have port overflow  output  1  sticky flag: a captured value was dropped.
REQ-011 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently buffered.

Function
REQ-012 SHALL keep register prev_a0, updated to a0 on every rising edge.
REQ-013 SHALL detect a change when en=1 and a0 != prev_a0 at a rising edge; it SHALL push a0 into the FIFO at that edge.
REQ-014 SHALL push at most one word per cycle, so a0 changing on consecutive cycles pushes one word per cycle.
REQ-015 SHALL drop the push and set overflow=1 when the FIFO is full and no pop occurs on the same edge.
REQ-016 SHALL accept the push when the FIFO is full and a pop occurs on the same edge; fifo_count stays FIFO_DEPTH.
REQ-017 SHALL clear overflow on an edge with clr_ovf=1; when a set and a clear coincide, the set wins.
REQ-018 SHALL use a transmitter FSM with states IDLE, START, DATA, STOP.
REQ-019 SHALL pop the FIFO head in IDLE when the FIFO is non-empty, and enter START on that same edge with byte index 0.
REQ-020 SHALL send the word as 4 bytes, a0[31:24] first and a0[7:0] last.
REQ-021 SHALL send each byte as follows:
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
- STOP: tx=1 for CLKS_PER_BIT cycles.
REQ-022 SHALL go from STOP to START for the next byte when the byte index is below 3; after byte 3 it SHALL go to IDLE.
REQ-023 SHALL give a full word frame of exactly 40*CLKS_PER_BIT cycles with no idle gap between its bytes.
REQ-024 SHALL allow a pop in IDLE on the edge the FSM enters IDLE, when the FIFO is non-empty, so back-to-back words have no gap.
REQ-025 SHALL drive tx from a register, so it is glitch-free.
REQ-026 SHALL, for a change pushed at edge E with the FIFO empty and the FSM in IDLE, pop the word and drive tx low from edge E+1.
REQ-027 SHALL keep the FIFO pointers modulo FIFO_DEPTH; fifo_count SHALL track pushes minus pops exactly across pointer wrap.
REQ-028 SHALL let en=0 stop new captures only; queued words and the frame in progress still complete.

Reset
REQ-029 SHALL, while rst=0, immediately force:
- tx=1, busy=0, overflow=0, fifo_count=0;
- FSM=IDLE, prev_a0=0, pointers=0.
REQ-030 SHALL abort any frame in progress on reset and discard all queued words.
REQ-031 SHALL detect a nonzero a0 on the first edge after rst deasserts as a change, because prev_a0=0.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-032 SHALL cover a single change: a0 goes 0 -> 0x12345678 and holds. tx SHALL carry bytes 0x12, 0x34, 0x56, 0x78 over 160 cycles, then stay high; fifo_count peaks at 1.
REQ-033 SHALL cover a burst: a0 takes 1, 2, 3, 4, 5, 6 on consecutive cycles, then holds. Words 1-5 SHALL be sent (1 popped on the cycle after its push), 6 SHALL be dropped, and overflow=1.
REQ-034 SHALL cover coincident push and pop: the FIFO is full and a pop coincides with a new change. The change SHALL be accepted, overflow SHALL stay 0, and fifo_count SHALL stay 4.
REQ-035 SHALL cover reset mid-frame: rst=0 during byte 2 of a frame. tx=1 immediately, and fifo_count=0 and busy=0 while rst=0. After release with a0 unchanged and nonzero, one word is re-sent.
REQ-036 SHALL cover en and clr_ovf:
- en=0 with a0 toggling for 10 cycles: no push, tx stays high.
- clr_ovf=1 pulse after overflow: overflow returns to 0 on the next edge.
REQ-037 SHALL cover pointer wrap: 9 single changes, each spaced 200 cycles apart. All 9 words SHALL be received intact and in order.

Source files
------------

// File: rtl/a0_uart_monitor.sv
// a0_uart_monitor: captures changes of CPU register a0 into a FIFO and streams each word MSB-byte-first over 8N1 UART
module a0_uart_monitor #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   a0,
    input  logic                          en,
    input  logic                          clr_ovf,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;

    logic [31:0]   prevA0;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0]   count;
    stateT         state, stateNext;
    logic [31:0]   word, wordNext;
    logic [1:0]    byteIdx, byteIdxNext;
    logic [2:0]    bitIdx, bitIdxNext;
    logic [CW-1:0] clkCnt, clkCntNext;
    logic          txNext;
    logic [7:0]    curByte;
    logic          change, full, empty, bitDone, frameEnd, pop, push, dropped;

    assign change   = en && (a0 != prevA0);
    assign full     = count == (AW+1)'(FIFO_DEPTH);
    assign empty    = count == '0;
    assign bitDone  = clkCnt == CW'(CLKS_PER_BIT - 1);
    // The last stop bit may pop directly so consecutive words run without a gap
    assign frameEnd = state == STOP && bitDone && byteIdx == 2'd3;
    assign pop      = !empty && (state == IDLE || frameEnd);
    assign push     = change && (!full || pop);
    assign dropped  = change && full && !pop;
    assign curByte  = word[31:24];

    assign busy       = state != IDLE || !empty;
    assign fifo_count = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prevA0   <= '0;
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            prevA0   <= a0;
            wrPtr    <= push ? wrPtr + 1'b1 : wrPtr;
            rdPtr    <= pop ? rdPtr + 1'b1 : rdPtr;
            count    <= count + (AW+1)'(push) - (AW+1)'(pop);
            overflow <= dropped || (overflow && !clr_ovf);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wrPtr] <= a0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            word    <= '0;
            byteIdx <= '0;
            bitIdx  <= '0;
            clkCnt  <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= stateNext;
            word    <= wordNext;
            byteIdx <= byteIdxNext;
            bitIdx  <= bitIdxNext;
            clkCnt  <= clkCntNext;
            tx      <= txNext;
        end
    end

    always_comb begin
        stateNext   = state;
        wordNext    = word;
        byteIdxNext = byteIdx;
        bitIdxNext  = bitIdx;
        clkCntNext  = bitDone ? '0 : clkCnt + 1'b1;
        txNext      = tx;
        if (pop) begin
            stateNext   = START;
            wordNext    = mem[rdPtr];
            byteIdxNext = '0;
            clkCntNext  = '0;
            txNext      = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clkCntNext = '0;
                    txNext     = 1'b1;
                end
                START: if (bitDone) begin
                    stateNext  = DATA;
                    bitIdxNext = '0;
                    txNext     = curByte[0];
                end
                DATA: if (bitDone) begin
                    stateNext  = bitIdx == 3'd7 ? STOP : DATA;
                    bitIdxNext = bitIdx == 3'd7 ? bitIdx : bitIdx + 3'd1;
                    txNext     = bitIdx == 3'd7 ? 1'b1 : curByte[bitIdx + 3'd1];
                end
                STOP: if (bitDone) begin
                    stateNext   = byteIdx == 2'd3 ? IDLE : START;
                    byteIdxNext = byteIdx == 2'd3 ? byteIdx : byteIdx + 2'd1;
                    wordNext    = {word[23:0], 8'h00};
                    txNext      = byteIdx == 2'd3;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_a0_uart_monitor.sv
// tb_a0_uart_monitor: directed vectors with a serial receiver model decoding tx back into bytes
module tb_a0_uart_monitor;
    localparam int CPB = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] a0 = '0;
    logic        en = 1'b1;
    logic        clrOvf = 1'b0;
    logic        tx, busy, overflow;
    logic [2:0]  fifoCount;

    int vecs = 0;
    int miscompares = 0;
    logic [7:0] rxBytes[$];

    a0_uart_monitor #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .a0(a0), .en(en), .clr_ovf(clrOvf),
        .tx(tx), .busy(busy), .overflow(overflow), .fifo_count(fifoCount)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkWord(string tag, logic [31:0] exp);
        logic [31:0] w = '0;
        if (rxBytes.size() < 4)
            check({tag, "_len"}, 32'(rxBytes.size()), 32'd4);
        else begin
            for (int i = 0; i < 4; i++)
                w = {w[23:0], rxBytes.pop_front()};
            check(tag, w, exp);
        end
    endtask

    // Receiver: start detected on a negedge, data sampled near mid-bit
    always begin
        @(negedge clk);
        if (rst && tx === 1'b0) begin
            logic [7:0] b;
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            check("stop_bit", 32'(tx), 32'd1);
            rxBytes.push_back(b);
        end
    end

    initial begin
        int bad;
        logic [31:0] vals[9];
        tick(3);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_count", 32'(fifoCount), 32'd0);
        rst = 1'b1;
        tick(3);

        // single change
        a0 = 32'h12345678;
        tick(1);
        check("single_count", 32'(fifoCount), 32'd1);
        check("single_tx_pre", 32'(tx), 32'd1);
        check("single_busy", 32'(busy), 32'd1);
        tick(1);
        check("single_tx_start", 32'(tx), 32'd0);
        check("single_popped", 32'(fifoCount), 32'd0);
        tick(170);
        checkWord("single_word", 32'h12345678);
        check("single_idle_busy", 32'(busy), 32'd0);
        check("single_idle_tx", 32'(tx), 32'd1);

        // burst of six, sixth dropped
        a0 = 32'd1; tick(1);
        a0 = 32'd2; tick(1);
        check("burst_e2_tx", 32'(tx), 32'd0);
        check("burst_e2_count", 32'(fifoCount), 32'd1);
        a0 = 32'd3; tick(1);
        a0 = 32'd4; tick(1);
        a0 = 32'd5; tick(1);
        check("burst_full", 32'(fifoCount), 32'd4);
        check("burst_ovf_pre", 32'(overflow), 32'd0);
        a0 = 32'd6; tick(1);
        check("burst_ovf", 32'(overflow), 32'd1);
        check("burst_count", 32'(fifoCount), 32'd4);
        clrOvf = 1'b1; tick(1);
        clrOvf = 1'b0;
        check("clr_ovf", 32'(overflow), 32'd0);

        // change coinciding with the pop of word 2 on a full FIFO
        tick(154);
        a0 = 32'd7;
        check("coinc_pre_count", 32'(fifoCount), 32'd4);
        tick(1);
        check("coinc_count", 32'(fifoCount), 32'd4);
        check("coinc_ovf", 32'(overflow), 32'd0);
        tick(820);
        checkWord("burst_w1", 32'd1);
        checkWord("burst_w2", 32'd2);
        checkWord("burst_w3", 32'd3);
        checkWord("burst_w4", 32'd4);
        checkWord("burst_w5", 32'd5);
        checkWord("burst_w7", 32'd7);
        check("burst_done_busy", 32'(busy), 32'd0);

        // capture disabled
        en = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            a0 = 32'h100 + 32'(i);
            tick(1);
            if (tx !== 1'b1 || fifoCount !== 3'd0) bad++;
        end
        check("en_off_quiet", 32'(bad), 32'd0);
        en = 1'b1;
        tick(50);
        check("en_on_count", 32'(fifoCount), 32'd0);
        check("en_rx_empty", 32'(rxBytes.size()), 32'd0);

        // reset mid-frame
        a0 = 32'hCAFEBABE; tick(1);
        a0 = 32'hDEADBEEF; tick(1);
        check("mid_count", 32'(fifoCount), 32'd1);
        tick(85);
        check("mid_tx_active_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_count", 32'(fifoCount), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        repeat (50) @(posedge clk);
        rxBytes.delete();
        #1 rst = 1'b1;
        tick(1);
        check("rerun_count", 32'(fifoCount), 32'd1);
        tick(175);
        checkWord("rerun_word", 32'hDEADBEEF);
        check("rerun_once", 32'(rxBytes.size()), 32'd0);

        // pointer wrap
        for (int k = 0; k < 9; k++) begin
            vals[k] = 32'h0F1E2D3C + 32'(k) * 32'h11111111;
            a0 = vals[k];
            tick(200);
            checkWord("wrap_word", vals[k]);
        end
        check("wrap_ovf", 32'(overflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
